// File: rtl/mem_load_unit_if.sv
// mem_load_unit_if: groups the load-request, data-RAM read and writeback signals
// of the load unit into one bundle.
// slave  = the load unit's view; master = the surrounding pipeline and memory.
interface mem_load_unit_if #(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
);
    // execute-stage request
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_funct3;
    logic [RD_W-1:0]   ld_rd;
    // data RAM read port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    // register-file writeback
    logic              wb_valid;
    logic              wb_we;
    logic [RD_W-1:0]   wb_rd;
    logic [31:0]       wb_data;
    logic              wb_err;

    modport slave (
        input  ld_valid, ld_addr, ld_funct3, ld_rd, mem_rvalid, mem_rdata,
        output ld_ready, mem_req, mem_addr, wb_valid, wb_we, wb_rd, wb_data, wb_err
    );

    modport master (
        output ld_valid, ld_addr, ld_funct3, ld_rd, mem_rvalid, mem_rdata,
        input  ld_ready, mem_req, mem_addr, wb_valid, wb_we, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/mem_load_unit.sv
// mem_load_unit: single-outstanding load unit. Accepts a load, issues one
// word-aligned RAM read, waits (bounded by TIMEOUT) for the response, then
// extracts and extends the addressed byte/halfword/word for writeback.
// Optional macro: LOAD_MISALIGN_TRAP_EN -- misaligned LH/LHU/LW become an
// immediate error writeback instead of an access.
module mem_load_unit #(
    parameter int ADDR_W  = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    mem_load_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t      state;
    logic [1:0]  off_q;      // byte offset inside the word
    logic [2:0]  f3_q;       // latched load type
    logic [7:0]  cnt;        // cycles spent in WAIT without a response
    logic        illegal;
    logic        misalign;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] ext;

    // Unit is ready only when idle and not held in reset.
    assign bus.ld_ready = (state == IDLE) && !rst;

    // Request decode: unsupported funct3 encodings and (optionally) misalignment.
    always_comb begin
        illegal = (bus.ld_funct3 == 3'b011) || (bus.ld_funct3 == 3'b110) ||
                  (bus.ld_funct3 == 3'b111);
`ifdef LOAD_MISALIGN_TRAP_EN
        misalign = ((bus.ld_funct3[1:0] == 2'b01) && bus.ld_addr[0]) ||
                   ((bus.ld_funct3 == 3'b010) && (bus.ld_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Lane select and sign/zero extension of the returned word.
    always_comb begin
        case (off_q)
            2'b00:   sel_b = bus.mem_rdata[7:0];
            2'b01:   sel_b = bus.mem_rdata[15:8];
            2'b10:   sel_b = bus.mem_rdata[23:16];
            default: sel_b = bus.mem_rdata[31:24];
        endcase
        sel_h = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (f3_q)
            3'b000:  ext = {{24{sel_b[7]}}, sel_b};
            3'b100:  ext = {24'h0, sel_b};
            3'b001:  ext = {{16{sel_h[15]}}, sel_h};
            3'b101:  ext = {16'h0, sel_h};
            default: ext = bus.mem_rdata;
        endcase
    end

    // Control FSM with registered memory and writeback outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            off_q        <= 2'b00;
            f3_q         <= 3'b000;
            cnt          <= 8'd0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_we    <= 1'b0;
            bus.wb_rd    <= '0;
            bus.wb_data  <= 32'h0;
            bus.wb_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ld_valid) begin
                        off_q     <= bus.ld_addr[1:0];
                        f3_q      <= bus.ld_funct3;
                        bus.wb_rd <= bus.ld_rd;
                        if (illegal || misalign) begin
                            // error exit without touching memory
                            state        <= WB;
                            bus.wb_valid <= 1'b1;
                            bus.wb_err   <= 1'b1;
                            bus.wb_we    <= 1'b0;
                            bus.wb_data  <= 32'h0;
                        end else begin
                            state        <= REQ;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {bus.ld_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                REQ: begin
                    // strobe lasts exactly one cycle; response ignored here
                    bus.mem_req <= 1'b0;
                    cnt         <= 8'd0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        // data beats a coincident timeout
                        state        <= WB;
                        bus.wb_valid <= 1'b1;
                        bus.wb_err   <= 1'b0;
                        bus.wb_data  <= ext;
                        bus.wb_we    <= (bus.wb_rd != '0);
                    end else if (cnt == 8'(TIMEOUT)) begin
                        state        <= WB;
                        bus.wb_valid <= 1'b1;
                        bus.wb_err   <= 1'b1;
                        bus.wb_data  <= 32'h0;
                        bus.wb_we    <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    // WB: one-cycle pulse, then back to idle
                    bus.wb_valid <= 1'b0;
                    bus.wb_we    <= 1'b0;
                    bus.wb_err   <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: table-driven loads with a writeback scoreboard, plus
// hand-written reset-state and reset-during-WAIT sequences.
module tb_mem_load_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_load_unit_if #(.ADDR_W(32), .RD_W(5)) bus ();

    mem_load_unit #(.ADDR_W(32), .RD_W(5), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          dly;     // negedges after mem_req seen before rvalid; -1 never
        logic [31:0] edata;
        logic        eerr;
        int          ereq;
        logic [31:0] emaddr;
        int          elat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        we;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [4:0] rd, input logic [31:0] rdata,
                                input int dly, input logic [31:0] edata,
                                input logic eerr, input int ereq,
                                input logic [31:0] emaddr, input int elat);
        vec_t v;
        v.f3 = f3; v.addr = addr; v.rd = rd; v.rdata = rdata; v.dly = dly;
        v.edata = edata; v.eerr = eerr; v.ereq = ereq; v.emaddr = emaddr; v.elat = elat;
        return v;
    endfunction

    // Scoreboard: every writeback pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && bus.wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected wb_valid", 32'(bus.wb_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_data", bus.wb_data, e.data);
                chk("wb_err", 32'(bus.wb_err), 32'(e.err));
                chk("wb_we", 32'(bus.wb_we), 32'(e.we));
                chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
            end
        end
    end

    task automatic run(input vec_t v, input int idx);
        int   w;
        int   reqs;
        int   rt;
        int   lat;
        exp_t e;
        string nm;
        nm = $sformatf("v%0d", idx);
        w = 0;
        while (!bus.ld_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " ld_ready"}, 32'(bus.ld_ready), 32'h1);
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = v.addr;
        bus.ld_funct3 = v.f3;
        bus.ld_rd     = v.rd;
        e.data = v.edata;
        e.err  = v.eerr;
        e.we   = !v.eerr && (v.rd != 5'd0);
        e.rd   = v.rd;
        sb.push_back(e);
        reqs = 0;
        rt   = -100;
        lat  = -1;
        for (int t = 0; t < 40 && lat < 0; t++) begin
            @(negedge clk);
            bus.ld_valid = 1'b0;
            if (bus.mem_req) begin
                reqs++;
                rt = t;
                chk({nm, " mem_addr"}, bus.mem_addr, v.emaddr);
            end
            bus.mem_rdata  = v.rdata;
            bus.mem_rvalid = (v.dly >= 0) && (rt >= 0) && (t == rt + v.dly);
            if (bus.wb_valid) lat = t + 1;
        end
        bus.mem_rvalid = 1'b0;
        chk({nm, " mem_req cycles"}, 32'(reqs), 32'(v.ereq));
        chk({nm, " latency"}, 32'(lat), 32'(v.elat));
        @(negedge clk);
        chk({nm, " ld_ready after wb"}, 32'(bus.ld_ready), 32'h1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " mem_req"}, 32'(bus.mem_req), 32'h0);
        chk({nm, " mem_addr"}, bus.mem_addr, 32'h0);
        chk({nm, " wb_valid"}, 32'(bus.wb_valid), 32'h0);
        chk({nm, " wb_we"}, 32'(bus.wb_we), 32'h0);
        chk({nm, " wb_rd"}, 32'(bus.wb_rd), 32'h0);
        chk({nm, " wb_data"}, bus.wb_data, 32'h0);
        chk({nm, " wb_err"}, 32'(bus.wb_err), 32'h0);
    endtask

    initial begin
        int wbs;
        bus.ld_valid   = 1'b0;
        bus.ld_addr    = 32'h0;
        bus.ld_funct3  = 3'b000;
        bus.ld_rd      = 5'd0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        // vectors: LW=010 LB=000 LH=001 LBU=100 LHU=101
        vecs.push_back(mk(3'b010, 32'h8,  5'd3,  32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0, 1, 32'h8,  3));
        vecs.push_back(mk(3'b000, 32'h7,  5'd5,  32'h80FF1234, 1, 32'hFFFFFF80, 1'b0, 1, 32'h4,  3));
        vecs.push_back(mk(3'b100, 32'h7,  5'd5,  32'h80FF1234, 1, 32'h00000080, 1'b0, 1, 32'h4,  3));
        vecs.push_back(mk(3'b001, 32'h6,  5'd6,  32'h80FF1234, 1, 32'hFFFF80FF, 1'b0, 1, 32'h4,  3));
        vecs.push_back(mk(3'b101, 32'h6,  5'd6,  32'h80FF1234, 1, 32'h000080FF, 1'b0, 1, 32'h4,  3));
        vecs.push_back(mk(3'b000, 32'h4,  5'd1,  32'h80FF1234, 1, 32'h00000034, 1'b0, 1, 32'h4,  3));
        vecs.push_back(mk(3'b100, 32'h5,  5'd2,  32'h80FF1234, 2, 32'h00000012, 1'b0, 1, 32'h4,  4));
        vecs.push_back(mk(3'b001, 32'h4,  5'd7,  32'h00008001, 1, 32'hFFFF8001, 1'b0, 1, 32'h4,  3));
        vecs.push_back(mk(3'b010, 32'h10, 5'd0,  32'h11223344, 1, 32'h11223344, 1'b0, 1, 32'h10, 3));
        vecs.push_back(mk(3'b011, 32'h0,  5'd4,  32'h0,        1, 32'h0,        1'b1, 0, 32'h0,  1));
        vecs.push_back(mk(3'b110, 32'h0,  5'd4,  32'h0,        1, 32'h0,        1'b1, 0, 32'h0,  1));
        vecs.push_back(mk(3'b111, 32'h0,  5'd4,  32'h0,        1, 32'h0,        1'b1, 0, 32'h0,  1));
`ifdef LOAD_MISALIGN_TRAP_EN
        vecs.push_back(mk(3'b010, 32'h6,  5'd8,  32'hCAFEF00D, 1, 32'h0,        1'b1, 0, 32'h4,  1));
        vecs.push_back(mk(3'b001, 32'h5,  5'd9,  32'h80FF1234, 1, 32'h0,        1'b1, 0, 32'h4,  1));
`else
        vecs.push_back(mk(3'b010, 32'h6,  5'd8,  32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0, 1, 32'h4,  3));
        vecs.push_back(mk(3'b001, 32'h5,  5'd9,  32'h80FF1234, 1, 32'h00001234, 1'b0, 1, 32'h4,  3));
`endif
        // rvalid on the edge the counter reaches TIMEOUT: data wins
        vecs.push_back(mk(3'b010, 32'h20, 5'd10, 32'h55AA55AA, 16, 32'h55AA55AA, 1'b0, 1, 32'h20, 18));
        vecs.push_back(mk(3'b010, 32'h24, 5'd11, 32'h01020304, 15, 32'h01020304, 1'b0, 1, 32'h24, 17));
        // no response: timeout error
        vecs.push_back(mk(3'b010, 32'h28, 5'd12, 32'h12345678, -1, 32'h0, 1'b1, 1, 32'h28, 18));
        // response only during REQ is ignored, so this also times out
        vecs.push_back(mk(3'b010, 32'h2C, 5'd13, 32'h87654321, 0, 32'h0, 1'b1, 1, 32'h2C, 18));

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset ld_ready", 32'(bus.ld_ready), 32'h0);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset ld_ready", 32'(bus.ld_ready), 32'h1);

        for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

        // reset during WAIT, then a late response after release
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h40;
        bus.ld_funct3 = 3'b010;
        bus.ld_rd     = 5'd14;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk("rstseq mem_req", 32'(bus.mem_req), 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstseq async ld_ready", 32'(bus.ld_ready), 32'h0);
        chk_all_zero("rstseq async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_rdata  = 32'hBADBAD00;
        bus.mem_rvalid = 1'b1;
        wbs = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (bus.wb_valid) wbs++;
        end
        chk("rstseq wb pulses", 32'(wbs), 32'h0);
        chk_all_zero("rstseq after");
        chk("rstseq ld_ready", 32'(bus.ld_ready), 32'h1);
        run(mk(3'b010, 32'h44, 5'd15, 32'h0BADF00D, 1, 32'h0BADF00D, 1'b0, 1, 32'h44, 3), 99);

        repeat (2) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
